// File: rtl/bmem_responder.sv
// bmem_responder: 256-bit line memory serving 4-beat 64-bit read/write bursts, with a latency-timed read queue.
// Build option: define BMEM_RESPONDER_CHECK_EN to enable the sticky protocol-violation flag on err.
module bmem_responder #(
  parameter int MEM_LINES    = 64,
  parameter int READ_LATENCY = 4,
  parameter int QDEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        err
);

  localparam int LW = $clog2(MEM_LINES);
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  typedef enum logic {IDLE, BURST} rstate_t;
  typedef enum logic [1:0] {WIDLE, WBEAT1, WBEAT2, WBEAT3} wstate_t;

  rstate_t rstate_reg, rstate_next;
  wstate_t wstate_reg, wstate_next;
  logic [1:0]    beat_reg, beat_next;
  logic [QW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [26:0]   qline_reg [QDEPTH];
  logic [3:0]    age_reg [QDEPTH];
  logic [LW-1:0] wline_reg;
  logic [63:0]   mem [MEM_LINES*4];

  logic          full, head_aged, push, pop, issue, we;
  logic [1:0]    rword, wword;
  logic [LW-1:0] wline;
  logic [26:0]   head_line;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bmem_addr[4:0];

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_reg == CW'(QDEPTH));
  assign head_line = qline_reg[rd_ptr_reg];
  assign head_aged = (count_reg != '0) && (age_reg[rd_ptr_reg] == LAT);
  assign push      = rst && (wstate_reg == WIDLE) && bmem_read && !bmem_write && !full;

  assign bmem_ready  = rst && ((wstate_reg != WIDLE) || !full);
  assign bmem_rvalid = rst && issue;
  assign bmem_raddr  = bmem_rvalid ? {head_line, 5'b0} : 32'd0;
  assign bmem_rdata  = bmem_rvalid ? mem[{head_line[LW-1:0], rword}] : 64'd0;

  // Read response FSM: the IDLE cycle that sees an aged head already issues beat 0,
  // which is what lets READ_LATENCY=1 and back-to-back bursts run without a gap.
  always_comb begin
    rstate_next = rstate_reg;
    beat_next   = beat_reg;
    issue       = 1'b0;
    pop         = 1'b0;
    rword       = 2'd0;
    case (rstate_reg)
      IDLE: begin
        if (head_aged) begin
          issue       = 1'b1;
          beat_next   = 2'd1;
          rstate_next = BURST;
        end
      end
      BURST: begin
        issue = 1'b1;
        rword = beat_reg;
        if (beat_reg == 2'd3) begin
          pop         = 1'b1;
          beat_next   = 2'd0;
          rstate_next = IDLE;
        end else begin
          beat_next = beat_reg + 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    wstate_next = wstate_reg;
    we          = 1'b0;
    wword       = 2'd0;
    wline       = wline_reg;
    case (wstate_reg)
      WIDLE: begin
        if (rst && bmem_write && !full) begin
          we          = 1'b1;
          wline       = bmem_addr[5 +: LW];
          wstate_next = WBEAT1;
        end
      end
      WBEAT1: begin
        we          = bmem_write;
        wword       = 2'd1;
        wstate_next = bmem_write ? WBEAT2 : WIDLE;
      end
      WBEAT2: begin
        we          = bmem_write;
        wword       = 2'd2;
        wstate_next = bmem_write ? WBEAT3 : WIDLE;
      end
      WBEAT3: begin
        we          = bmem_write;
        wword       = 2'd3;
        wstate_next = WIDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_reg <= IDLE;
      wstate_reg <= WIDLE;
      beat_reg   <= 2'd0;
      wline_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rstate_reg <= rstate_next;
      wstate_reg <= wstate_next;
      beat_reg   <= beat_next;
      wline_reg  <= wline;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Age counts cycles since acceptance, so a slot holds 1 in the cycle after its push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) age_reg[i] <= 4'd0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && (wr_ptr_reg == QW'(i))) age_reg[i] <= 4'd1;
        else if (age_reg[i] != LAT)         age_reg[i] <= age_reg[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) qline_reg[wr_ptr_reg] <= bmem_addr[31:5];
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wline, wword}] <= bmem_wdata;
  end

`ifdef BMEM_RESPONDER_CHECK_EN
  logic        err_reg, violation;
  logic [31:0] waddr_reg;

  always_comb begin
    violation = 1'b0;
    if (wstate_reg == WIDLE) violation = bmem_read && (bmem_write || full);
    else violation = bmem_read || !bmem_write || (bmem_addr != waddr_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg   <= 1'b0;
      waddr_reg <= 32'd0;
    end else begin
      if (violation) err_reg <= 1'b1;
      if (wstate_reg == WIDLE) waddr_reg <= bmem_addr;
    end
  end

  assign err = rst && err_reg;
`else
  assign err = 1'b0;
`endif

endmodule
